// File: rtl/arith_arbiter.sv
// Shares one registered signed arithmetic unit among NUM_REQ requesters, one operation in flight.
// Build option: define ARITH_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round robin.
module arith_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned in_width  = 4,
  parameter int unsigned out_width = 16,
  parameter int unsigned ID_W      = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*in_width-1:0] req_a,
  input  logic [NUM_REQ*in_width-1:0] req_b,
  input  logic [NUM_REQ*2-1:0]        req_func,
  output logic [in_width-1:0]         alu_a,
  output logic [in_width-1:0]         alu_b,
  output logic [1:0]                  alu_func,
  output logic                        alu_enable,
  input  logic [out_width-1:0]        alu_out,
  input  logic                        alu_carry,
  input  logic                        alu_flag,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [ID_W-1:0]             rsp_id,
  output logic [out_width-1:0]        rsp_data,
  output logic                        rsp_carry,
  output logic                        rsp_div0
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StResp  = 2'd3;

  localparam logic [1:0] FuncDiv = 2'b11;

  logic [1:0]           state_q, state_d;
  logic [ID_W-1:0]      ptr;

  logic [in_width-1:0]  alu_a_q, alu_b_q;
  logic [1:0]           alu_func_q;
  logic [ID_W-1:0]      rsp_id_q;
  logic [out_width-1:0] rsp_data_q;
  logic                 rsp_carry_q, rsp_div0_q;

  logic                 hi_any, lo_any, gnt_any;
  logic [ID_W-1:0]      hi_id, lo_id, gnt_id;
  logic [NUM_REQ-1:0]   gnt_oh;
  logic [in_width-1:0]  gnt_a, gnt_b;
  logic [1:0]           gnt_f;
  logic                 gnt_div0;

  // The flag only matters to whoever checks the arith unit; the arbiter forwards regardless.
  logic unused_flag;
  assign unused_flag = alu_flag;

  // Grant: first valid at or above the pointer, otherwise wrap to the lowest valid index.
  always_comb begin
    hi_any = 1'b0;
    hi_id  = '0;
    lo_any = 1'b0;
    lo_id  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!hi_any && req_valid[i] && (ID_W'(i) >= ptr)) begin
        hi_any = 1'b1;
        hi_id  = ID_W'(i);
      end
      if (!lo_any && req_valid[i]) begin
        lo_any = 1'b1;
        lo_id  = ID_W'(i);
      end
    end
    gnt_any = lo_any;
    gnt_id  = hi_any ? hi_id : lo_id;
  end

  always_comb begin
    gnt_oh = '0;
    gnt_a  = '0;
    gnt_b  = '0;
    gnt_f  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_any && (gnt_id == ID_W'(i))) begin
        gnt_oh[i] = 1'b1;
        gnt_a     = req_a[i*in_width +: in_width];
        gnt_b     = req_b[i*in_width +: in_width];
        gnt_f     = req_func[i*2 +: 2];
      end
    end
    gnt_div0 = (gnt_f == FuncDiv) && (gnt_b == '0);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (gnt_any) state_d = gnt_div0 ? StResp : StIssue;
      StIssue: state_d = StWait;
      StWait:  state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_func_q  <= '0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == StIdle) && gnt_any) begin
        alu_a_q    <= gnt_a;
        alu_b_q    <= gnt_b;
        alu_func_q <= gnt_f;
        rsp_id_q   <= gnt_id;
        // Divide-by-zero never reaches the unit; the trap response is formed right here.
        if (gnt_div0) begin
          rsp_data_q  <= '0;
          rsp_carry_q <= 1'b0;
          rsp_div0_q  <= 1'b1;
        end
      end
      if (state_q == StWait) begin
        rsp_data_q  <= alu_out;
        rsp_carry_q <= alu_carry;
        rsp_div0_q  <= 1'b0;
      end
    end
  end

`ifdef ARITH_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [ID_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if ((state_q == StResp) && rsp_ready) begin
      ptr_d = (rsp_id_q == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id_q + ID_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;
`endif

  // Gated by reset so no grant escapes while the block is held in reset.
  assign req_ready  = ((state_q == StIdle) && rst) ? gnt_oh : '0;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_func   = alu_func_q;
  assign alu_enable = (state_q == StIssue);
  assign rsp_valid  = (state_q == StResp);
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_div0   = rsp_div0_q;

`ifndef SYNTHESIS
  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(req_ready));
  a_ready_valid:  assert property (@(posedge clk) disable iff (!rst)
                                   ((req_ready & ~req_valid) == '0));
  a_rsp_stable:   assert property (@(posedge clk) disable iff (!rst)
                                   (rsp_valid && !rsp_ready) |=>
                                   (rsp_valid && $stable(rsp_data) && $stable(rsp_id)));
`endif

endmodule

// File: doc/arith_arbiter.md
Name: arith_arbiter

Overview:
- Round-robin scheduler that shares one registered signed arithmetic unit (add/sub/mul/div, 1-cycle registered output, enable-gated) between NUM_REQ requesters.
- Accepts one operation at a time over per-requester valid/ready, drives the unit's operand/function/enable inputs and captures its registered result.
- Returns the result with the requester id over a valid/ready response port.
- Traps divide-by-zero without issuing it to the unit.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
in_width, 4, signed operand width
out_width, 16, result width
ID_W, 2, requester id width, must be >= clog2(NUM_REQ)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester accept, one-hot, one cycle
req_a  input  NUM_REQ*in_width  packed signed operand a; slice i belongs to requester i
req_b  input  NUM_REQ*in_width  packed signed operand b
req_func  input  NUM_REQ*2  packed op: 00 add, 01 sub, 10 mul, 11 div
alu_a  output  in_width  operand a to arith unit
alu_b  output  in_width  operand b to arith unit
alu_func  output  2  function select to arith unit
alu_enable  output  1  arith enable, high only in ISSUE
alu_out  input  out_width  registered result from arith unit
alu_carry  input  1  registered carry from arith unit
alu_flag  input  1  registered valid flag from arith unit
rsp_valid  output  1  response valid
rsp_ready  input  1  response accept
rsp_id  output  ID_W  index of requester served
rsp_data  output  out_width  result
rsp_carry  output  1  carry
rsp_div0  output  1  divide-by-zero trap, rsp_data forced 0

Behaviour:
- Reset (rst=0, asynchronous):
  - State=IDLE, round-robin pointer=0.
  - All outputs 0: req_ready, alu_a, alu_b, alu_func, alu_enable, rsp_*.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid, grant g = first set bit at or after pointer, wrapping modulo NUM_REQ.
  - Assert req_ready[g] combinationally in this cycle.
  - Latch slice g of a/b/func into alu_a/alu_b/alu_func at the edge; latch g into rsp_id.
  - Next state: RESP if func=11 and b=0, else ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: alu_enable=1 for exactly one cycle; the arith unit registers its result at this edge. Next: WAIT.
- WAIT:
  - alu_enable=0; capture alu_out to rsp_data and alu_carry to rsp_carry; rsp_div0=0.
  - If alu_flag=0 the arith unit has failed: still capture and respond (flag is checked by the bench).
  - Next: RESP.
- Div-by-zero path: rsp_data=0, rsp_carry=0, rsp_div0=1 captured on the IDLE edge; alu_enable never asserted.
- RESP:
  - rsp_valid=1; rsp_id/rsp_data/rsp_carry/rsp_div0 held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: rsp_valid drops next cycle, pointer=(rsp_id+1) mod NUM_REQ, state=IDLE.
- No new request is accepted while not in IDLE; at most one op in flight.
- Latency:
  - Normal op: accept edge to rsp_valid high = 3 clk.
  - Div0: 1 clk.
  - Minimum throughput: 1 op per 4 clk (div0: per 2 clk).
- req_ready is never asserted for a requester whose req_valid is low.
- Holding req_valid low after deassert mid-wait has no effect; the operation is already captured.
- Reset mid-operation aborts immediately: the in-flight op is dropped with no response, and the pointer returns to 0.
- Arithmetic width and sign rules are owned by the arith unit; the arbiter passes operand bits unmodified.

Optional Feature:
- Macro: ARITH_ARB_FIXED_PRIO_EN.
- Defined: grant is fixed priority, lowest index wins; the pointer register is removed and stays 0.
- Undefined (default): round robin as above.

Test Plan:
- Single op: req 0 a=3 b=2 func=00, rsp_ready=1 -> req_ready[0] pulse, 3 clk later rsp_valid, rsp_id=0, rsp_data=16'd5, rsp_div0=0.
- Round robin: req 0..3 all valid continuously -> grants in order 0,1,2,3,0; each served once per 4 responses.
- Div0: req 2 a=5 b=0 func=11 -> alu_enable never high, rsp_valid 1 clk after accept, rsp_id=2, rsp_data=0, rsp_div0=1.
- Backpressure: rsp_ready=0 for 5 clk on a mul a=3 b=3 -> rsp_valid and rsp_data=16'd9 held stable, req_ready stays 0 until handshake.
- Reset mid-op: assert rst=0 during WAIT -> all outputs 0 immediately; after release, first grant goes to requester 0, no stale response.
- Macro defined: req 1 and req 3 valid continuously -> req 1 granted every time.
